// File: rtl/cv32e40p_x_copro_resp.sv
// Coprocessor-side XIF responder: decodes custom-0 ALU ops, queues them in order,
// executes each after commit with a fixed latency and returns the result.
module cv32e40p_x_copro_resp #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned LATENCY = 2,
   parameter logic [6:0]  OPCODE  = 7'b0001011
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        x_issue_valid_i,
   output logic        x_issue_ready_o,
   input  logic [31:0] x_issue_req_instr_i,
   input  logic [3:0]  x_issue_req_id_i,
   input  logic [63:0] x_issue_req_rs_i,
   input  logic [2:0]  x_issue_req_rs_valid_i,
   output logic        x_issue_resp_accept_o,
   output logic        x_issue_resp_writeback_o,
   output logic        x_issue_resp_loadstore_o,
   input  logic        x_commit_valid_i,
   input  logic [3:0]  x_commit_id_i,
   input  logic        x_commit_kill_i,
   output logic        x_result_valid_o,
   input  logic        x_result_ready_i,
   output logic [3:0]  x_result_id_o,
   output logic [31:0] x_result_data_o,
   output logic [4:0]  x_result_rd_o,
   output logic        x_result_we_o
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned LAT_W = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   state_e state, state_n;

   logic [3:0]  q_id [DEPTH];
   logic [1:0]  q_op [DEPTH];
   logic [4:0]  q_rd [DEPTH];
   logic [31:0] q_a  [DEPTH];
   logic [31:0] q_b  [DEPTH];
   logic [DEPTH-1:0] q_vld, q_com, q_kil, hit;
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [LAT_W-1:0] cnt;

   logic match, full, push, pop, load_cnt, latch, new_hit;
   logic unused_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   function automatic logic [31:0] alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a ^ b;
         default: return ($signed(a) < $signed(b)) ? a : b;
      endcase
   endfunction

   // Issue-side decode and handshake qualification
   assign match   = (x_issue_req_instr_i[6:0] == OPCODE) && (x_issue_req_instr_i[14] == 1'b0);
   assign full    = (count == CNT_W'(DEPTH));
   assign x_issue_ready_o          = rst_ni & ~full & x_issue_req_rs_valid_i[0] & x_issue_req_rs_valid_i[1];
   assign x_issue_resp_accept_o    = match;
   assign x_issue_resp_writeback_o = match;
   assign x_issue_resp_loadstore_o = 1'b0;
   assign push    = x_issue_valid_i & x_issue_ready_o & match;
   assign new_hit = x_commit_valid_i & (x_commit_id_i == x_issue_req_id_i);
   assign unused_ok = ^{x_issue_req_rs_valid_i[2], x_issue_req_instr_i[31:15]};

   // Commit ID match against every live queue entry
   for (genvar g = 0; g < DEPTH; g++) begin : g_hit
      assign hit[g] = x_commit_valid_i & q_vld[g] & (q_id[g] == x_commit_id_i);
   end

   // Queue control and per-entry status flags
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         q_vld <= '0;
         q_com <= '0;
         q_kil <= '0;
      end else begin
         if (x_commit_valid_i) begin
            if (x_commit_kill_i) q_kil <= q_kil | hit;
            else                 q_com <= q_com | hit;
         end
         if (push) begin
            q_vld[tail] <= 1'b1;
            q_com[tail] <= new_hit & ~x_commit_kill_i;
            q_kil[tail] <= new_hit & x_commit_kill_i;
            tail        <= ptr_inc(tail);
         end
         if (pop) begin
            q_vld[head] <= 1'b0;
            head        <= ptr_inc(head);
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Queue payload storage; only read while the entry is live
   always_ff @(posedge clk_i) begin
      if (push) begin
         q_id[tail] <= x_issue_req_id_i;
         q_op[tail] <= x_issue_req_instr_i[13:12];
         q_rd[tail] <= x_issue_req_instr_i[11:7];
         q_a[tail]  <= x_issue_req_rs_i[31:0];
         q_b[tail]  <= x_issue_req_rs_i[63:32];
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_n;
   end

   // FSM next-state logic
   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (q_vld[head] && !q_kil[head] && q_com[head]) state_n = EXEC;
         EXEC: if (cnt == '0) state_n = RESP;
         RESP: if (x_result_ready_i) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // FSM outputs: pops, latency load, result latch, result valid
   always_comb begin
      pop              = 1'b0;
      load_cnt         = 1'b0;
      latch            = 1'b0;
      x_result_valid_o = 1'b0;
      case (state)
         IDLE: begin
            pop      = q_vld[head] & q_kil[head];
            load_cnt = q_vld[head] & ~q_kil[head] & q_com[head];
         end
         EXEC: latch = (cnt == '0);
         RESP: begin
            x_result_valid_o = 1'b1;
            pop              = x_result_ready_i;
         end
         default: ;
      endcase
   end

   // Execute latency counter
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                          cnt <= '0;
      else if (load_cnt)                    cnt <= LAT_W'(LATENCY - 1);
      else if (state == EXEC && cnt != '0)  cnt <= cnt - 1'b1;
   end

   // Result registers, held stable through RESP
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         x_result_id_o   <= '0;
         x_result_data_o <= '0;
         x_result_rd_o   <= '0;
         x_result_we_o   <= 1'b0;
      end else if (latch) begin
         x_result_id_o   <= q_id[head];
         x_result_data_o <= alu(q_op[head], q_a[head], q_b[head]);
         x_result_rd_o   <= q_rd[head];
         x_result_we_o   <= (q_rd[head] != 5'd0);
      end
   end

endmodule

// File: tb/tb_cv32e40p_x_copro_resp.sv
// Directed self-checking bench for the XIF coprocessor responder.
module tb_cv32e40p_x_copro_resp;

   localparam logic [6:0] CUST0 = 7'b0001011;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        x_issue_valid_i;
   logic        x_issue_ready_o;
   logic [31:0] x_issue_req_instr_i;
   logic [3:0]  x_issue_req_id_i;
   logic [63:0] x_issue_req_rs_i;
   logic [2:0]  x_issue_req_rs_valid_i;
   logic        x_issue_resp_accept_o;
   logic        x_issue_resp_writeback_o;
   logic        x_issue_resp_loadstore_o;
   logic        x_commit_valid_i;
   logic [3:0]  x_commit_id_i;
   logic        x_commit_kill_i;
   logic        x_result_valid_o;
   logic        x_result_ready_i;
   logic [3:0]  x_result_id_o;
   logic [31:0] x_result_data_o;
   logic [4:0]  x_result_rd_o;
   logic        x_result_we_o;

   int checks   = 0;
   int failures = 0;

   cv32e40p_x_copro_resp dut (
      .clk_i                    (clk_i),
      .rst_ni                   (rst_ni),
      .x_issue_valid_i          (x_issue_valid_i),
      .x_issue_ready_o          (x_issue_ready_o),
      .x_issue_req_instr_i      (x_issue_req_instr_i),
      .x_issue_req_id_i         (x_issue_req_id_i),
      .x_issue_req_rs_i         (x_issue_req_rs_i),
      .x_issue_req_rs_valid_i   (x_issue_req_rs_valid_i),
      .x_issue_resp_accept_o    (x_issue_resp_accept_o),
      .x_issue_resp_writeback_o (x_issue_resp_writeback_o),
      .x_issue_resp_loadstore_o (x_issue_resp_loadstore_o),
      .x_commit_valid_i         (x_commit_valid_i),
      .x_commit_id_i            (x_commit_id_i),
      .x_commit_kill_i          (x_commit_kill_i),
      .x_result_valid_o         (x_result_valid_o),
      .x_result_ready_i         (x_result_ready_i),
      .x_result_id_o            (x_result_id_o),
      .x_result_data_o          (x_result_data_o),
      .x_result_rd_o            (x_result_rd_o),
      .x_result_we_o            (x_result_we_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
      return {17'h0, f3, rd, opc};
   endfunction

   // One issue cycle; checks the comb handshake outputs, leaves us one cycle later
   task automatic offer(input string tag, input logic [31:0] instr, input logic [3:0] id,
                        input logic [31:0] a, input logic [31:0] b, input logic commit,
                        input logic exp_ready, input logic exp_acc);
      x_issue_valid_i        = 1'b1;
      x_issue_req_instr_i    = instr;
      x_issue_req_id_i       = id;
      x_issue_req_rs_i       = {b, a};
      x_issue_req_rs_valid_i = 3'b011;
      x_commit_valid_i       = commit;
      x_commit_id_i          = id;
      x_commit_kill_i        = 1'b0;
      #1;
      chk({tag, "_ready"},  32'(x_issue_ready_o), 32'(exp_ready));
      chk({tag, "_accept"}, 32'(x_issue_resp_accept_o), 32'(exp_acc));
      chk({tag, "_wb"},     32'(x_issue_resp_writeback_o), 32'(exp_acc));
      @(posedge clk_i);
      #1;
      x_issue_valid_i  = 1'b0;
      x_commit_valid_i = 1'b0;
   endtask

   task automatic wait_result(input string tag);
      int n = 0;
      while (x_result_valid_o !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_timeout"}, 32'(x_result_valid_o), 32'd1);
   endtask

   task automatic no_result(input string tag, input int cycles);
      int seen = 0;
      for (int i = 0; i < cycles; i++) begin
         if (x_result_valid_o !== 1'b0) seen++;
         tick();
      end
      chk({tag, "_noresult"}, 32'(seen), 32'd0);
   endtask

   initial begin
      rst_ni                 = 1'b0;
      x_issue_valid_i        = 1'b0;
      x_issue_req_instr_i    = '0;
      x_issue_req_id_i       = '0;
      x_issue_req_rs_i       = '0;
      x_issue_req_rs_valid_i = 3'b011;
      x_commit_valid_i       = 1'b0;
      x_commit_id_i          = '0;
      x_commit_kill_i        = 1'b0;
      x_result_ready_i       = 1'b1;

      // Reset values
      tick();
      tick();
      chk("rst_ready",    32'(x_issue_ready_o), 32'd0);
      chk("rst_rvalid",   32'(x_result_valid_o), 32'd0);
      chk("rst_rid",      32'(x_result_id_o), 32'd0);
      chk("rst_rdata",    x_result_data_o, 32'd0);
      chk("rst_rrd",      32'(x_result_rd_o), 32'd0);
      chk("rst_rwe",      32'(x_result_we_o), 32'd0);
      chk("rst_accept",   32'(x_issue_resp_accept_o), 32'd0);
      chk("rst_ls",       32'(x_issue_resp_loadstore_o), 32'd0);
      rst_ni = 1'b1;
      tick();

      // ADD with exact latency: result in cycle 4
      offer("add", mk(CUST0, 3'b000, 5'd3), 4'd2, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i < 4; i++) begin
         chk("add_early", 32'(x_result_valid_o), 32'd0);
         tick();
      end
      chk("add_valid", 32'(x_result_valid_o), 32'd1);
      chk("add_id",    32'(x_result_id_o), 32'd2);
      chk("add_data",  x_result_data_o, 32'd12);
      chk("add_rd",    32'(x_result_rd_o), 32'd3);
      chk("add_we",    32'(x_result_we_o), 32'd1);
      chk("add_ls",    32'(x_issue_resp_loadstore_o), 32'd0);
      tick();
      chk("add_after", 32'(x_result_valid_o), 32'd0);

      // Declines: wrong opcode, unsupported funct3
      offer("dec_opc", mk(7'b0110011, 3'b000, 5'd1), 4'd3, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
      offer("dec_f3",  mk(CUST0, 3'b111, 5'd1), 4'd4, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
      no_result("dec", 8);
      chk("dec_count", 32'(dut.count), 32'd0);

      // Kill drops the entry; following ID still answered
      offer("kill", mk(CUST0, 3'b000, 5'd4), 4'd5, 32'd9, 32'd9, 1'b0, 1'b1, 1'b1);
      x_commit_valid_i = 1'b1;
      x_commit_id_i    = 4'd5;
      x_commit_kill_i  = 1'b1;
      tick();
      x_commit_valid_i = 1'b0;
      x_commit_kill_i  = 1'b0;
      no_result("kill", 6);
      chk("kill_count", 32'(dut.count), 32'd0);
      offer("kill_next", mk(CUST0, 3'b000, 5'd6), 4'd6, 32'd1, 32'd1, 1'b1, 1'b1, 1'b1);
      wait_result("kill_next");
      chk("kill_next_id",   32'(x_result_id_o), 32'd6);
      chk("kill_next_data", x_result_data_o, 32'd2);
      tick();

      // Backpressure and full queue
      x_result_ready_i = 1'b0;
      for (int k = 0; k < 4; k++)
         offer("fill", mk(CUST0, 3'b000, 5'd7), 4'(8 + k), 32'(100 + k), 32'(k), 1'b1, 1'b1, 1'b1);
      offer("full", mk(CUST0, 3'b000, 5'd7), 4'd12, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         wait_result("bp");
         chk("bp_id",   32'(x_result_id_o), 32'(8 + k));
         chk("bp_data", x_result_data_o, 32'(100 + 2 * k));
         tick();
         tick();
         chk("bp_hold_valid", 32'(x_result_valid_o), 32'd1);
         chk("bp_hold_id",    32'(x_result_id_o), 32'(8 + k));
         chk("bp_hold_data",  x_result_data_o, 32'(100 + 2 * k));
         x_result_ready_i = 1'b1;
         tick();
         x_result_ready_i = 1'b0;
      end
      x_result_ready_i = 1'b1;
      no_result("bp_drain", 6);

      // Arithmetic edges
      offer("sub", mk(CUST0, 3'b001, 5'd1), 4'd1, 32'd0, 32'd1, 1'b1, 1'b1, 1'b1);
      wait_result("sub");
      chk("sub_data", x_result_data_o, 32'hFFFF_FFFF);
      chk("sub_we",   32'(x_result_we_o), 32'd1);
      tick();
      offer("min", mk(CUST0, 3'b011, 5'd2), 4'd7, 32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b1);
      wait_result("min");
      chk("min_data", x_result_data_o, 32'h8000_0000);
      tick();
      offer("xor0", mk(CUST0, 3'b010, 5'd0), 4'd9, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 1'b1, 1'b1);
      wait_result("xor0");
      chk("xor0_data", x_result_data_o, 32'h0000_FF00);
      chk("xor0_rd",   32'(x_result_rd_o), 32'd0);
      chk("xor0_we",   32'(x_result_we_o), 32'd0);
      tick();

      // Reset while a result is pending, with another entry queued
      x_result_ready_i = 1'b0;
      offer("rr_a", mk(CUST0, 3'b000, 5'd5), 4'd1, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
      offer("rr_b", mk(CUST0, 3'b000, 5'd5), 4'd2, 32'd3, 32'd4, 1'b1, 1'b1, 1'b1);
      wait_result("rr");
      rst_ni = 1'b0;
      #1;
      chk("rr_valid", 32'(x_result_valid_o), 32'd0);
      chk("rr_count", 32'(dut.count), 32'd0);
      tick();
      rst_ni = 1'b1;
      x_result_ready_i = 1'b1;
      no_result("rr_after", 8);
      chk("rr_count_after", 32'(dut.count), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
